interval_timer_arbiter: RTL

- Shares one down-counting interval timer between NREQ requesters.
- Each requester asks for a timed interval of a given length. A round-robin arbiter grants the timer to one requester, loads and runs the counter, then pulses a per-requester done.
- Sits beside the counter primitives as the controller that sequences and time-shares a single counter resource.

---
 rtl/interval_timer_arbiter_if.sv | 21 ++
 rtl/interval_timer_arbiter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/interval_timer_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : interval_timer_arbiter_if
// Brief    : Request/grant bundle between requesters and the shared timer.
// Revision : 1.0 - initial release
// ============================================================================
interface interval_timer_arbiter_if #(
   parameter int NREQ = 4,
   parameter int CW   = 8
);
   logic [NREQ-1:0]    req;
   logic [NREQ*CW-1:0] len;
   logic [NREQ-1:0]    grant;
   logic [CW-1:0]      count;
   logic [NREQ-1:0]    done;
   logic               busy;

   modport master (output req, len, input grant, count, done, busy);
   modport slave  (input req, len, output grant, count, done, busy);
endinterface
`default_nettype wire

// File: rtl/interval_timer_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : interval_timer_arbiter
// Brief    : Round-robin time-sharing of one down-counting interval timer.
// Revision : 1.0 - initial release
// ============================================================================
module interval_timer_arbiter #(
   parameter int NREQ = 4,
   parameter int CW   = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   interval_timer_arbiter_if.slave   bus
);

   localparam int c_PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_COUNT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t            r_state,  w_state_nxt;
   logic [c_PW-1:0]   r_ptr,    w_ptr_nxt;
   logic [c_PW-1:0]   r_owner,  w_owner_nxt;
   logic [NREQ-1:0]   r_grant,  w_grant_nxt;
   logic [NREQ-1:0]   r_done,   w_done_nxt;
   logic [CW-1:0]     r_count,  w_count_nxt;
   logic [c_PW-1:0]   w_win;
   logic [c_PW-1:0]   w_owner_inc;
   logic [CW-1:0]     w_win_len;
   logic              w_any_req;

   // Walk downward so the lowest offset from r_ptr is the last (winning) write.
   always_comb begin
      w_win = r_ptr;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (bus.req[(int'(r_ptr) + i) % NREQ]) begin
            w_win = c_PW'((int'(r_ptr) + i) % NREQ);
         end
      end
   end

   always_comb begin
      w_win_len = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (c_PW'(i) == w_win) begin
            w_win_len = bus.len[i*CW +: CW];
         end
      end
   end

   assign w_any_req   = |bus.req;
   assign w_owner_inc = (r_owner == c_PW'(NREQ - 1)) ? '0 : r_owner + 1'b1;

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_owner_nxt = r_owner;
      w_grant_nxt = r_grant;
      w_done_nxt  = '0;
      w_count_nxt = r_count;
      case (r_state)
         S_IDLE: begin
            if (w_any_req) begin
               w_owner_nxt = w_win;
               w_grant_nxt = NREQ'(1) << w_win;
               w_count_nxt = w_win_len;
               if (w_win_len == '0) begin
                  w_done_nxt  = NREQ'(1) << w_win;
                  w_state_nxt = S_DONE;
               end else begin
                  w_state_nxt = S_COUNT;
               end
            end
         end
         S_COUNT: begin
            if (!bus.req[r_owner]) begin
               w_grant_nxt = '0;
               w_count_nxt = '0;
               w_ptr_nxt   = w_owner_inc;
               w_state_nxt = S_IDLE;
            end else if (r_count == CW'(1)) begin
               w_count_nxt = '0;
               w_done_nxt  = r_grant;
               w_state_nxt = S_DONE;
            end else if (r_count != '0) begin
               w_count_nxt = r_count - 1'b1;
            end
         end
         S_DONE: begin
            w_grant_nxt = '0;
            w_count_nxt = '0;
            w_ptr_nxt   = w_owner_inc;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_grant_nxt = '0;
            w_count_nxt = '0;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_ptr   <= '0;
         r_owner <= '0;
         r_grant <= '0;
         r_done  <= '0;
         r_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_owner <= w_owner_nxt;
         r_grant <= w_grant_nxt;
         r_done  <= w_done_nxt;
         r_count <= w_count_nxt;
      end
   end

   assign bus.grant = r_grant;
   assign bus.count = r_count;
   assign bus.done  = r_done;
   assign bus.busy  = |r_grant;

endmodule
`default_nettype wire
